// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - data-bus interface for the memory-mapped UART transmitter
// Purpose: groups the SOPC data-bus signals seen by mmio_uart_tx.
// Signals:
//   i_ce    chip select from the address decoder
//   i_we    write enable (1 = write, 0 = read)
//   i_sel   byte lanes
//   i_addr  byte address
//   i_data  write data
//   o_data  read data, driven combinationally by the slave
interface mmio_uart_tx_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_ce;
   logic              i_we;
   logic [3:0]        i_sel;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_data;
   logic [DATA_W-1:0] o_data;

   modport master (output i_ce, i_we, i_sel, i_addr, i_data, input o_data);
   modport slave  (input i_ce, i_we, i_sel, i_addr, i_data, output o_data);
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt
// Purpose: buffers CPU-written bytes in a FIFO and serialises them 8N1 on o_txd.
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   bus      data-bus slave (ce/we/sel/addr/wdata in, combinational rdata out)
//   o_txd    serial output, idle high
//   o_irq    level interrupt: irq_en & FIFO empty & transmitter idle
// Registers (i_addr[3:2]): 0 TXDATA, 1 STATUS, 2 CTRL, 3 BAUDDIV.
module mmio_uart_tx #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 8,
   parameter int BAUD_DIV_RST = 433
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   mmio_uart_tx_if.slave bus,
   output logic          o_txd,
   output logic          o_irq
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [1:0] A_TXDATA = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;
   localparam logic [1:0] A_BAUD   = 2'd3;

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [1:0]        state_q, state_d;
   logic [15:0]       baud_cnt_q, baud_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q, txd_d;
   logic              irq_q, irq_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [15:0]       baud_div_q, baud_div_d;
   logic              ovf_q, ovf_d;

   logic [1:0]        reg_sel;
   logic              wr_en, push_req, push, pop;
   logic              full, empty, bit_end, tx_en, irq_en;
   logic [3:0]        cnt_disp;
   logic [DATA_W-1:0] rdata;
   logic              unused_bits;

   assign reg_sel  = bus.i_addr[3:2];
   assign wr_en    = bus.i_ce & bus.i_we & (bus.i_sel == 4'b1111);
   assign push_req = wr_en & (reg_sel == A_TXDATA);
   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign push     = push_req & (~full | pop);
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign bit_end  = (baud_cnt_q == 16'd0);
   assign tx_en    = ctrl_q[0];
   assign irq_en   = ctrl_q[1];
   assign o_txd    = txd_q;
   assign o_irq    = irq_q;

   assign unused_bits = ^{bus.i_addr[ADDR_W-1:4], bus.i_addr[1:0], bus.i_data[DATA_W-1:16]};

   // txd_d carries the line level of the bit being entered, so o_txd is glitch-free.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      txd_d      = txd_q;
      pop        = 1'b0;
      if (state_q != S_IDLE && !bit_end) begin
         baud_cnt_d = baud_cnt_q - 16'd1;
      end
      case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (tx_en && !empty) begin
               pop        = 1'b1;
               shift_d    = fifo_mem[rd_ptr_q];
               state_d    = S_START;
               baud_cnt_d = baud_div_q;
               txd_d      = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d    = S_DATA;
               bit_idx_d  = 3'd0;
               baud_cnt_d = baud_div_q;
               txd_d      = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_cnt_d = baud_div_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  txd_d     = shift_q[1];
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (tx_en && !empty) begin
                  // Back-to-back: next start bit follows the stop bit with no idle gap.
                  pop        = 1'b1;
                  shift_d    = fifo_mem[rd_ptr_q];
                  state_d    = S_START;
                  baud_cnt_d = baud_div_q;
                  txd_d      = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_comb begin
      ctrl_d     = ctrl_q;
      baud_div_d = baud_div_q;
      ovf_d      = ovf_q;
      if (wr_en) begin
         case (reg_sel)
            A_STATUS: if (bus.i_data[3]) ovf_d = 1'b0;
            A_CTRL:   ctrl_d     = bus.i_data[1:0];
            A_BAUD:   baud_div_d = bus.i_data[15:0];
            default:  ;
         endcase
      end
      if (push_req && !push) ovf_d = 1'b1;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      irq_d = irq_en & empty & (state_q == S_IDLE);
   end

   always_comb begin
      cnt_disp = (int'(count_q) > 15) ? 4'hF : 4'(count_q);
      rdata    = '0;
      if (bus.i_ce && !bus.i_we) begin
         case (reg_sel)
            A_STATUS: begin
               rdata[0]    = full;
               rdata[1]    = empty;
               rdata[2]    = (state_q != S_IDLE);
               rdata[3]    = ovf_q;
               rdata[11:8] = cnt_disp;
            end
            A_CTRL:  rdata[1:0]  = ctrl_q;
            A_BAUD:  rdata[15:0] = baud_div_q;
            default: ;
         endcase
      end
   end
   assign bus.o_data = rdata;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
         irq_q      <= 1'b0;
         ctrl_q     <= '0;
         baud_div_q <= 16'(BAUD_DIV_RST);
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         irq_q      <= irq_d;
         ctrl_q     <= ctrl_d;
         baud_div_q <= baud_div_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr_q] <= bus.i_data[7:0];
   end
endmodule
